// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard/forwarding scheduler.
// Holds the operand-source encodings, the scoreboard slot layout and the slot match/priority helpers.
package id_hazard_ctrl_pkg;

    localparam int SLOT_WD = 7;

    typedef enum logic [1:0] {
        FWD_SEL_RF = 2'd0,
        FWD_SEL_ES = 2'd1,
        FWD_SEL_MS = 2'd2,
        FWD_SEL_WS = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } slot_t;

    // A destination of $0 never produces a value worth waiting for or forwarding.
    function automatic logic slot_match(input slot_t slot, input logic [4:0] src, input logic ren);
        return slot.valid && (slot.dest != 5'd0) && (slot.dest == src) && ren;
    endfunction

    // The youngest writer holds the architecturally newest value.
    function automatic fwd_sel_e pick_fwd(input logic es_hit, input logic ms_hit, input logic ws_hit);
        if (es_hit)
            return FWD_SEL_ES;
        else if (ms_hit)
            return FWD_SEL_MS;
        else if (ws_hit)
            return FWD_SEL_WS;
        else
            return FWD_SEL_RF;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_hazard_slot.sv
// One scoreboard entry shadowing the destination held by a single in-flight pipeline stage.
// Compares the held destination against both ID source operands.
module hazard_slot
    import id_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic       clr,
    input  slot_t      d,
    output slot_t      q,
    input  logic [4:0] rs,
    input  logic       rs_ren,
    input  logic [4:0] rt,
    input  logic       rt_ren,
    output logic       rs_match,
    output logic       rt_match
);

    // A load always beats a clear: a stage refilled in the same cycle it drains stays occupied.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load_en)
            q <= d;
        else if (clr)
            q.valid <= 1'b0;
    end

    assign rs_match = slot_match(q, rs, rs_ren);
    assign rt_match = slot_match(q, rt, rt_ren);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard and forwarding scheduler for the ID stage of the five-stage pipeline.
// Define ID_HAZARD_FWD_EN for EX/MEM/WB forwarding; otherwise it is a pure interlock.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds_valid,
    input  logic [4:0]       ds_rs,
    input  logic [4:0]       ds_rt,
    input  logic             ds_rs_ren,
    input  logic             ds_rt_ren,
    input  logic [4:0]       ds_dest,
    input  logic             ds_load,
    input  logic             ds_fire,
    input  logic             es_fire,
    input  logic             ms_fire,
    input  logic             ws_fire,
    output logic             ds_stall,
    output logic [1:0]       rs_fwd_sel,
    output logic [1:0]       rt_fwd_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t es_d;
    slot_t es_q;
    slot_t ms_q;
    logic  es_rs_match, es_rt_match;
    logic  ms_rs_match, ms_rt_match;
    logic  ws_rs_match, ws_rt_match;

    assign es_d = '{valid: 1'b1, dest: ds_dest, load: ds_load};

    hazard_slot u_es_slot (
        .clk      (clk),
        .reset    (reset),
        .load_en  (ds_fire),
        .clr      (es_fire),
        .d        (es_d),
        .q        (es_q),
        .rs       (ds_rs),
        .rs_ren   (ds_rs_ren),
        .rt       (ds_rt),
        .rt_ren   (ds_rt_ren),
        .rs_match (es_rs_match),
        .rt_match (es_rt_match)
    );

    hazard_slot u_ms_slot (
        .clk      (clk),
        .reset    (reset),
        .load_en  (es_fire),
        .clr      (ms_fire),
        .d        (es_q),
        .q        (ms_q),
        .rs       (ds_rs),
        .rs_ren   (ds_rs_ren),
        .rt       (ds_rt),
        .rt_ren   (ds_rt_ren),
        .rs_match (ms_rs_match),
        .rt_match (ms_rt_match)
    );

    hazard_slot u_ws_slot (
        .clk      (clk),
        .reset    (reset),
        .load_en  (ms_fire),
        .clr      (ws_fire),
        .d        (ms_q),
        .q        (),
        .rs       (ds_rs),
        .rs_ren   (ds_rs_ren),
        .rt       (ds_rt),
        .rt_ren   (ds_rt_ren),
        .rs_match (ws_rs_match),
        .rt_match (ws_rt_match)
    );

`ifdef ID_HAZARD_FWD_EN
    // Only load data is still missing while in EX; everything else can be forwarded.
    assign rs_fwd_sel = pick_fwd(es_rs_match, ms_rs_match, ws_rs_match);
    assign rt_fwd_sel = pick_fwd(es_rt_match, ms_rt_match, ws_rt_match);
    assign ds_stall   = ds_valid && es_q.load && (es_rs_match || es_rt_match);
`else
    // Without bypass paths the reader waits until the writer has left WB.
    assign rs_fwd_sel = FWD_SEL_RF;
    assign rt_fwd_sel = FWD_SEL_RF;
    assign ds_stall   = ds_valid && (es_rs_match || es_rt_match ||
                                     ms_rs_match || ms_rt_match ||
                                     ws_rs_match || ws_rt_match);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (ds_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl; expectations follow ID_HAZARD_FWD_EN when defined.
// Inputs change 1 time unit after each rising edge and outputs are sampled 1 unit later.
module tb_id_hazard_ctrl;

`ifdef ID_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             ds_valid;
    logic [4:0]       ds_rs;
    logic [4:0]       ds_rt;
    logic             ds_rs_ren;
    logic             ds_rt_ren;
    logic [4:0]       ds_dest;
    logic             ds_load;
    logic             ds_fire;
    logic             es_fire;
    logic             ms_fire;
    logic             ws_fire;
    logic             ds_stall;
    logic [1:0]       rs_fwd_sel;
    logic [1:0]       rt_fwd_sel;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic es_busy_model;

    id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ds_valid   (ds_valid),
        .ds_rs      (ds_rs),
        .ds_rt      (ds_rt),
        .ds_rs_ren  (ds_rs_ren),
        .ds_rt_ren  (ds_rt_ren),
        .ds_dest    (ds_dest),
        .ds_load    (ds_load),
        .ds_fire    (ds_fire),
        .es_fire    (es_fire),
        .ms_fire    (ms_fire),
        .ws_fire    (ws_fire),
        .ds_stall   (ds_stall),
        .rs_fwd_sel (rs_fwd_sel),
        .rt_fwd_sel (rt_fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing into an occupied EX stage that is not draining would corrupt the scoreboard.
    always @(posedge clk) begin
        if (!reset && ds_fire && es_busy_model && !es_fire) begin
            failures++;
            $display("[TB] FAIL illegal_issue: ds_fire=1 while EX occupied, required ds_fire=0");
        end
        if (reset)
            es_busy_model <= 1'b0;
        else if (ds_fire)
            es_busy_model <= 1'b1;
        else if (es_fire)
            es_busy_model <= 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ds_valid  = 1'b0;
        ds_rs     = 5'd0;
        ds_rt     = 5'd0;
        ds_rs_ren = 1'b0;
        ds_rt_ren = 1'b0;
        ds_dest   = 5'd0;
        ds_load   = 1'b0;
        ds_fire   = 1'b0;
        es_fire   = 1'b0;
        ms_fire   = 1'b0;
        ws_fire   = 1'b0;
    endtask

    task automatic clear_fires();
        ds_fire = 1'b0;
        es_fire = 1'b0;
        ms_fire = 1'b0;
        ws_fire = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dest, input logic load);
        ds_valid = 1'b1;
        ds_dest  = dest;
        ds_load  = load;
        ds_fire  = 1'b1;
    endtask

    task automatic reader(input logic [4:0] rs, input logic rs_ren, input logic [4:0] rt, input logic rt_ren);
        ds_valid  = 1'b1;
        ds_rs     = rs;
        ds_rs_ren = rs_ren;
        ds_rt     = rt;
        ds_rt_ren = rt_ren;
        ds_dest   = 5'd20;
        ds_load   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reader(5'd3, 1'b1, 5'd4, 1'b1);
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b required 0", ds_stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_rs_fwd: got %0d required 0", rs_fwd_sel); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_rt_fwd: got %0d required 0", rt_fwd_sel); end
        checks++; if (stall_cnt !== 3'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d required 0", stall_cnt); end
    endtask

    task automatic test_alu_chain();
        do_reset();
        issue(5'd7, 1'b0);
        tick();
        clear_inputs();
        reader(5'd2, 1'b1, 5'd7, 1'b1);
        es_fire = 1'b1;
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL alu_es_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("[TB] FAIL alu_es_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 1 : 0); end
        checks++; if (rs_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL alu_es_rs_fwd: got %0d required 0", rs_fwd_sel); end
        tick();
        clear_fires();
        ms_fire = 1'b1;
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL alu_ms_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("[TB] FAIL alu_ms_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 2 : 0); end
        tick();
        clear_fires();
        ws_fire = 1'b1;
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL alu_ws_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd3 : 2'd0)) begin failures++; $display("[TB] FAIL alu_ws_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 3 : 0); end
        tick();
        clear_fires();
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_retired_stall: got %0b required 0", ds_stall); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL alu_retired_rt_fwd: got %0d required 0", rt_fwd_sel); end
        checks++; if (stall_cnt !== (FWD ? 3'd0 : 3'd3)) begin failures++; $display("[TB] FAIL alu_cnt: got %0d required %0d", stall_cnt, FWD ? 0 : 3); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(5'd5, 1'b1);
        tick();
        clear_inputs();
        reader(5'd5, 1'b1, 5'd0, 1'b1);
        es_fire = 1'b1;
        #1;
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_es_stall: got %0b required 1", ds_stall); end
        checks++; if (rs_fwd_sel !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("[TB] FAIL lu_es_rs_fwd: got %0d required %0d", rs_fwd_sel, FWD ? 1 : 0); end
        checks++; if (stall_cnt !== 3'd0) begin failures++; $display("[TB] FAIL lu_es_cnt: got %0d required 0", stall_cnt); end
        tick();
        clear_fires();
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL lu_ms_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rs_fwd_sel !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("[TB] FAIL lu_ms_rs_fwd: got %0d required %0d", rs_fwd_sel, FWD ? 2 : 0); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL lu_ms_rt_fwd: got %0d required 0", rt_fwd_sel); end
        checks++; if (stall_cnt !== 3'd1) begin failures++; $display("[TB] FAIL lu_ms_cnt: got %0d required 1", stall_cnt); end
    endtask

    task automatic test_youngest();
        do_reset();
        issue(5'd4, 1'b0);
        tick();
        clear_inputs();
        es_fire = 1'b1;
        tick();
        clear_inputs();
        ms_fire = 1'b1;
        issue(5'd4, 1'b0);
        tick();
        clear_inputs();
        reader(5'd4, 1'b1, 5'd4, 1'b1);
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL young_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rs_fwd_sel !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("[TB] FAIL young_rs_fwd: got %0d required %0d", rs_fwd_sel, FWD ? 1 : 0); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("[TB] FAIL young_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 1 : 0); end
        ds_rs_ren = 1'b0;
        #1;
        checks++; if (rs_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL noren_rs_fwd: got %0d required 0", rs_fwd_sel); end
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL noren_rt_stall: got %0b required %0b", ds_stall, !FWD); end
        ds_rt_ren = 1'b0;
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL noren_stall: got %0b required 0", ds_stall); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL noren_rt_fwd: got %0d required 0", rt_fwd_sel); end
    endtask

    task automatic test_dest_zero();
        do_reset();
        issue(5'd0, 1'b1);
        tick();
        clear_inputs();
        reader(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL zero_stall: got %0b required 0", ds_stall); end
        checks++; if (rs_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL zero_rs_fwd: got %0d required 0", rs_fwd_sel); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL zero_rt_fwd: got %0d required 0", rt_fwd_sel); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(5'd8, 1'b0);
        tick();
        clear_inputs();
        issue(5'd9, 1'b0);
        es_fire = 1'b1;
        tick();
        clear_inputs();
        reader(5'd8, 1'b1, 5'd9, 1'b1);
        es_fire = 1'b1;
        ms_fire = 1'b1;
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL b2b_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rs_fwd_sel !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("[TB] FAIL b2b_rs_fwd: got %0d required %0d", rs_fwd_sel, FWD ? 2 : 0); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("[TB] FAIL b2b_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 1 : 0); end
        tick();
        clear_fires();
        ms_fire = 1'b1;
        ws_fire = 1'b1;
        #1;
        checks++; if (rs_fwd_sel !== (FWD ? 2'd3 : 2'd0)) begin failures++; $display("[TB] FAIL shift_rs_fwd: got %0d required %0d", rs_fwd_sel, FWD ? 3 : 0); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("[TB] FAIL shift_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 2 : 0); end
        tick();
        clear_fires();
        #1;
        checks++; if (ds_stall !== (FWD ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL replace_stall: got %0b required %0b", ds_stall, !FWD); end
        checks++; if (rs_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL replace_rs_fwd: got %0d required 0", rs_fwd_sel); end
        checks++; if (rt_fwd_sel !== (FWD ? 2'd3 : 2'd0)) begin failures++; $display("[TB] FAIL replace_rt_fwd: got %0d required %0d", rt_fwd_sel, FWD ? 3 : 0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(5'd10, 1'b0);
        tick();
        clear_inputs();
        issue(5'd11, 1'b0);
        es_fire = 1'b1;
        tick();
        clear_inputs();
        issue(5'd12, 1'b1);
        es_fire = 1'b1;
        ms_fire = 1'b1;
        tick();
        clear_inputs();
        reader(5'd12, 1'b1, 5'd10, 1'b1);
        #1;
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_stall: got %0b required 1", ds_stall); end
        reset   = 1'b1;
        ds_fire = 1'b1;
        es_fire = 1'b1;
        ms_fire = 1'b1;
        tick();
        reset = 1'b0;
        clear_fires();
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_stall: got %0b required 0", ds_stall); end
        checks++; if (stall_cnt !== 3'd0) begin failures++; $display("[TB] FAIL post_reset_cnt: got %0d required 0", stall_cnt); end
        checks++; if (rt_fwd_sel !== 2'd0) begin failures++; $display("[TB] FAIL post_reset_rt_fwd: got %0d required 0", rt_fwd_sel); end
    endtask

    task automatic test_saturate();
        do_reset();
        issue(5'd5, 1'b1);
        tick();
        clear_inputs();
        reader(5'd5, 1'b1, 5'd1, 1'b0);
        #1;
        checks++; if (ds_stall !== 1'b1) begin failures++; $display("[TB] FAIL sat_stall: got %0b required 1", ds_stall); end
        repeat (5) tick();
        checks++; if (stall_cnt !== 3'd5) begin failures++; $display("[TB] FAIL sat_cnt5: got %0d required 5", stall_cnt); end
        repeat (5) tick();
        checks++; if (stall_cnt !== 3'd7) begin failures++; $display("[TB] FAIL sat_cnt_max: got %0d required 7", stall_cnt); end
        ds_valid = 1'b0;
        #1;
        checks++; if (ds_stall !== 1'b0) begin failures++; $display("[TB] FAIL novalid_stall: got %0b required 0", ds_stall); end
        tick();
        checks++; if (stall_cnt !== 3'd7) begin failures++; $display("[TB] FAIL novalid_cnt: got %0d required 7", stall_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        $display("[TB] forwarding mode = %0b", FWD);
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_dest_zero();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete, required completion before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and forwarding scheduler for the five-stage CPU pipeline. It keeps a registered shadow scoreboard of the destination register held in each in-flight stage (EX, MEM, WB). Each cycle it decides whether the instruction in ID may issue. It also tells ID which source, register file or EX/MEM/WB result, feeds each operand. ID instantiates it and uses its outputs to gate `ds_ready_go` and steer the `rs`/`rt` operand muxes.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `ds_valid`  in  1  ID holds a valid instruction.
- `ds_rs`, `ds_rt`  in  5 each  source register numbers of the ID instruction.
- `ds_rs_ren`, `ds_rt_ren`  in  1 each  the ID instruction actually reads `rs` / `rt`.
- `ds_dest`  in  5  destination of the ID instruction; 0 means no write.
- `ds_load`  in  1  the ID instruction is a load.
- `ds_fire`  in  1  ID→EX transfer this cycle (`ds_to_es_valid & es_allowin`).
- `es_fire`  in  1  EX→MEM transfer this cycle.
- `ms_fire`  in  1  MEM→WB transfer this cycle.
- `ws_fire`  in  1  WB retires its instruction this cycle.
- `ds_stall`  out  1  ID must not issue (`ds_ready_go = !ds_stall`).
- `rs_fwd_sel`, `rt_fwd_sel`  out  2 each  operand source: 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
- `stall_cnt`  out  `CNT_W`  number of cycles with `ds_valid & ds_stall`.

## Operation
- Three slots: ES, MS, WS. Each slot holds `{valid, dest[4:0], load}`.
- Slot update per cycle, all evaluated in parallel:
  - ES slot: `ds_fire` loads `{1, ds_dest, ds_load}`. Otherwise, `es_fire` clears valid.
  - MS slot: `es_fire` loads the old ES slot. Otherwise, `ms_fire` clears valid.
  - WS slot: `ms_fire` loads the old MS slot. Otherwise, `ws_fire` clears valid.
- A slot matches source `s` when all of the following hold: slot valid, `dest != 0`, `dest == s`, and the source's `ren` is set.
- Forward priority is ES > MS > WS; the youngest writer wins. `fwd_sel` is the nearest matching slot, or 0 if no slot matches.
- Load-use stall (with `FWD_EN`): `ds_stall` is asserted when `ds_valid` and either source matches an ES slot whose `load` = 1. Load data becomes forwardable from MEM onward.
- `ds_stall` and `fwd_sel` are combinational from the slots and the `ds_*` fields only. They never depend on `ds_fire`, so no combinational loop forms.
- `stall_cnt` increments when `ds_valid & ds_stall`. It saturates at all-ones.

## Timing
- Reset values:
  - All slots invalid.
  - `ds_stall` = 0.
  - Both `fwd_sel` = 0.
  - `stall_cnt` = 0.
- A load issued at cycle t sits in the ES slot at t+1. A dependent instruction in ID stalls at t+1 and sees `fwd_sel` = 2 at t+2 if MEM holds.
- Simultaneous `ds_fire` and `es_fire`: the ES slot takes the new instruction, and the MS slot takes the old ES contents in the same edge.
- `ms_fire` and `ws_fire` together: the WS slot is replaced, not cleared.
- `ds_fire` while ES is valid and `es_fire` = 0 is illegal. The bench asserts this never happens.
- `reset` mid-operation clears all slots on the next edge regardless of fire inputs.
- When `ds_valid` = 0, `ds_stall` = 0 and the counter holds.

## Configuration
- `ID_HAZARD_FWD_EN` defined: forwarding as above; only a load in ES stalls.
- Undefined: both `fwd_sel` are tied to 0, and the block operates as a pure interlock. `ds_stall` is asserted whenever any valid slot matches either source. The stall holds until the writer leaves the WS slot, so the RF write-back is visible to the read.

## Structure
- `mycpu.h` gains the `FWD_SEL_RF`/`ES`/`MS`/`WS` encodings and `SLOT_WD` = 7.
- One sub-module, `hazard_slot`. It is a single scoreboard register with `load_en`, `clr`, `d` and `q`, plus a `match(s, ren)` output. It is instantiated three times.
- Stall, priority logic and the counter live in the top module.

## Test plan
- `addu $3` issued, then `addu` reading `$3` next cycle → `rs_fwd_sel` = 1, `ds_stall` = 0.
- `lw $5`, then `beq $5,$0` → stall for 1 cycle, `stall_cnt` = 1, then `rs_fwd_sel` = 2.
- Writes to `$4` sitting in ES and WS, reader of `$4` in ID → `fwd_sel` = 1 (youngest).
- Writer with `dest` = 0 in ES, reader of `$0` → `fwd_sel` = 0, no stall.
- `ID_HAZARD_FWD_EN` undefined: `addu $7` then reader of `$7` → stall 3 cycles until `ws_fire`, `fwd_sel` = 0 throughout.
- `reset` asserted with all slots valid and a pending load-use → next cycle `ds_stall` = 0, `stall_cnt` = 0.
